idex_stage_reg: RTL and testbench
=================================

IDEX_STAGE_REG -- requirements
Module: idex_stage_reg

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, giving the width of the performance counters in REQ-030.
REQ-002 The block SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 The block SHALL have ports IDRegRs / IDRegRt / IDRegRd  input  5 each  register numbers decoded in ID.
REQ-005 The block SHALL have ports IDRD1 / IDRD2 / IDImm32  input  32 each  register-file read data and extended immediate.
REQ-006 The block SHALL have port IDCtrl  input  10  control bundle {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, RegDst, ALUOp[3:0]}, MSB first.
REQ-007 The block SHALL have port IDUsesRt  input  1  1 when the ID instruction reads rt as a source.
REQ-008 The block SHALL have port IDValid  input  1  1 when the ID slot holds a real instruction.
REQ-009 The block SHALL have port BranchFlush  input  1  taken branch/jump resolved in EX; squash the ID instruction.
REQ-010 The block SHALL have port ExtStall  input  1  memory-side hold; freeze the front end and ID/EX.
REQ-011 The block SHALL have ports IDEXRegRs / IDEXRegRt / IDEXRegRd  output  5 each  registered register numbers, feeding the forwarding unit.
REQ-012 The block SHALL have ports IDEXRD1 / IDEXRD2 / IDEXImm32  output  32 each  registered data.
REQ-013 The block SHALL have ports IDEXRegWrite, IDEXMemRead, IDEXMemWrite, IDEXMemtoReg, IDEXALUSrc, IDEXRegDst  output  1 each, and port IDEXALUOp  output  4  registered control.
REQ-014 The block SHALL have port IDEXValid  output  1  registered valid.
REQ-015 The block SHALL have ports PCWrite / IFIDWrite  output  1 each  front-end enables; 0 holds PC or IF/ID.
REQ-016 The block SHALL have port LoadUseStall  output  1  combinational load-use hazard flag.

Function
REQ-017 The block SHALL assert LoadUseStall = IDValid & IDEXValid & IDEXMemRead & (IDEXRegRt != 0) & ((IDEXRegRt == IDRegRs) | (IDUsesRt & (IDEXRegRt == IDRegRt))).
REQ-018 At each clock edge the block SHALL apply exactly one action, in this priority: rst > ExtStall > BranchFlush > LoadUseStall > load.
REQ-019 HOLD (ExtStall=1): all ID/EX registers SHALL keep their values, and PCWrite=0, IFIDWrite=0.
REQ-020 FLUSH (BranchFlush=1, ExtStall=0): the block SHALL load a bubble with PCWrite=1, IFIDWrite=1; the flush SHALL override a coincident LoadUseStall.
REQ-021 STALL (LoadUseStall=1 only): the block SHALL load a bubble with PCWrite=0, IFIDWrite=0.
REQ-022 LOAD: the block SHALL capture all ID inputs into ID/EX; IDEXValid SHALL take IDValid; PCWrite=1, IFIDWrite=1.
REQ-023 A bubble SHALL set all control outputs, IDEXValid, register numbers and data to 0, so that the forwarding unit sees Rs=Rt=Rd=0 and forwards nothing.
REQ-024 The FSM SHALL have states RUN, LU_BUBBLE and HOLD. The next state SHALL be HOLD on ExtStall, otherwise LU_BUBBLE on STALL, otherwise RUN.
REQ-025 In LU_BUBBLE, LoadUseStall SHALL be 0 by construction, because the bubble has MemRead=0. A stall therefore lasts exactly 1 cycle, and the block SHALL perform LOAD or FLUSH next.
REQ-026 On leaving HOLD, the block SHALL re-evaluate REQ-018 using the current inputs. A hazard present on entry to HOLD SHALL still produce its bubble after HOLD ends.
REQ-027 PCWrite, IFIDWrite and LoadUseStall SHALL be combinational from the current inputs and state, with zero-cycle latency. ID/EX outputs SHALL have 1-cycle latency.

Reset
REQ-028 While rst=1, all ID/EX outputs SHALL be 0 at the next edge and the state SHALL be RUN; reset SHALL override ExtStall and BranchFlush.
REQ-029 While rst=1, PCWrite and IFIDWrite SHALL be 1 and LoadUseStall SHALL be 0.

Configuration
REQ-030 With IDEX_PERF_CNT_EN defined, the block SHALL add outputs StallCnt and FlushCnt (CNT_W each).
- StallCnt counts STALL cycles; FlushCnt counts FLUSH cycles.
- Both counters saturate at all-ones and clear on rst.
- Without the macro, these ports and registers SHALL be absent, and the remaining behaviour SHALL be identical.

Verification
REQ-031 Load-use on rs: ID/EX holds lw $8 (MemRead=1, Rt=8); ID holds add with Rs=8 -> LoadUseStall=1 and PCWrite=IFIDWrite=0 for one cycle; next cycle IDEXValid=0 and IDEXRegRs=0; the cycle after, add is loaded with IDEXRegRs=8.
REQ-032 No false hazard: ID/EX holds lw $0; ID holds Rs=0 -> LoadUseStall=0. ID/EX holds lw $9; ID holds Rt=9 with IDUsesRt=0 -> LoadUseStall=0.
REQ-033 Priority: BranchFlush=1 and LoadUseStall=1 in the same cycle -> bubble loaded, PCWrite=1; with ExtStall=1 also asserted -> registers unchanged, PCWrite=0.
REQ-034 Hold: ExtStall=1 for 3 cycles with IDRD1=0xDEADBEEF changing -> IDEXRD1 keeps its prior value for all 3 cycles, then loads 0xDEADBEEF after release.
REQ-035 Reset mid-stall: assert rst during LU_BUBBLE -> next edge gives all outputs 0 and state RUN; with IDEX_PERF_CNT_EN defined, StallCnt=0.
REQ-036 Counter saturation (IDEX_PERF_CNT_EN defined, CNT_W=4): 20 STALL events -> StallCnt=15.

Source files
------------

// File: rtl/idex_stage_reg.sv
// -----------------------------------------------------------------------------
// idex_stage_reg
//
// ID/EX pipeline register of a 5-stage MIPS-style pipeline, together with the
// load-use hazard detector and the front-end write enables that go with it.
//
// Every rising clk edge applies exactly one action, highest priority first:
//   RESET (rst)        : ID/EX cleared, FSM -> RUN, front end enabled
//   HOLD  (ExtStall)   : ID/EX frozen, PC and IF/ID frozen
//   FLUSH (BranchFlush): bubble into ID/EX, front end advances
//   STALL (load-use)   : bubble into ID/EX, PC and IF/ID frozen
//   LOAD               : ID inputs captured into ID/EX
// A bubble is all zeros: no control, not valid, and Rs/Rt/Rd = 0, so the
// forwarding unit never matches against it.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   IDRegRs/Rt/Rd     [4:0]     register numbers decoded in ID
//   IDRD1/IDRD2/IDImm32 [31:0]  register-file read data, extended immediate
//   IDCtrl            [9:0]     {RegWrite, MemRead, MemWrite, MemtoReg,
//                                ALUSrc, RegDst, ALUOp[3:0]}
//   IDUsesRt, IDValid           rt is a source / ID slot holds an instruction
//   BranchFlush, ExtStall       squash ID instruction / freeze everything
//   IDEX*                       registered ID/EX contents
//   PCWrite, IFIDWrite          front-end enables (0 holds PC / IF/ID)
//   LoadUseStall                combinational load-use hazard flag
//   StallCnt, FlushCnt [CNT_W]  saturating STALL / FLUSH cycle counters
//
// Build option
//   IDEX_PERF_CNT_EN  when defined, adds StallCnt/FlushCnt and their
//                     registers; otherwise they are absent.
// -----------------------------------------------------------------------------
module idex_stage_reg #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       IDRegRs,
  input  logic [4:0]       IDRegRt,
  input  logic [4:0]       IDRegRd,
  input  logic [31:0]      IDRD1,
  input  logic [31:0]      IDRD2,
  input  logic [31:0]      IDImm32,
  input  logic [9:0]       IDCtrl,
  input  logic             IDUsesRt,
  input  logic             IDValid,
  input  logic             BranchFlush,
  input  logic             ExtStall,
  output logic [4:0]       IDEXRegRs,
  output logic [4:0]       IDEXRegRt,
  output logic [4:0]       IDEXRegRd,
  output logic [31:0]      IDEXRD1,
  output logic [31:0]      IDEXRD2,
  output logic [31:0]      IDEXImm32,
  output logic             IDEXRegWrite,
  output logic             IDEXMemRead,
  output logic             IDEXMemWrite,
  output logic             IDEXMemtoReg,
  output logic             IDEXALUSrc,
  output logic             IDEXRegDst,
  output logic [3:0]       IDEXALUOp,
  output logic             IDEXValid,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             LoadUseStall
`ifdef IDEX_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
`endif
);

  // Counters need at least one bit; caught at elaboration.
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("idex_stage_reg: CNT_W must be at least 1");
  end

  typedef enum logic [1:0] {
    RUN,
    LU_BUBBLE,
    HOLD
  } state_e;

  typedef enum logic [2:0] {
    ACT_RESET,
    ACT_HOLD,
    ACT_FLUSH,
    ACT_STALL,
    ACT_LOAD
  } action_e;

  // Field order matches the IDCtrl bundle, MSB first.
  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       reg_dst;
    logic [3:0] alu_op;
  } ctrl_t;

  typedef struct packed {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    ctrl_t       ctrl;
    logic        valid;
  } idex_t;

  state_e  state_q, state_d;
  action_e action;
  idex_t   idex_q, idex_d;
  idex_t   id_in;
  logic    load_use;

  // ---------------------------------------------------------------------------
  // Hazard detection and action selection
  // ---------------------------------------------------------------------------
  always_comb begin
    id_in       = '0;
    id_in.rs    = IDRegRs;
    id_in.rt    = IDRegRt;
    id_in.rd    = IDRegRd;
    id_in.rd1   = IDRD1;
    id_in.rd2   = IDRD2;
    id_in.imm   = IDImm32;
    id_in.ctrl  = ctrl_t'(IDCtrl);
    id_in.valid = IDValid;
  end

  always_comb begin
    load_use = IDValid & idex_q.valid & idex_q.ctrl.mem_read &
               (idex_q.rt != '0) &
               ((idex_q.rt == IDRegRs) | (IDUsesRt & (idex_q.rt == IDRegRt)));
    // In LU_BUBBLE the register holds a bubble (MemRead=0), so this gate
    // never changes the result; it only makes the one-cycle stall explicit.
    if (state_q == LU_BUBBLE) begin
      load_use = 1'b0;
    end
  end

  always_comb begin
    action = ACT_LOAD;
    if (rst) begin
      action = ACT_RESET;
    end else if (ExtStall) begin
      action = ACT_HOLD;
    end else if (BranchFlush) begin
      action = ACT_FLUSH;
    end else if (load_use) begin
      action = ACT_STALL;
    end
  end

  always_comb begin
    LoadUseStall = ~rst & load_use;
    PCWrite      = 1'b1;
    IFIDWrite    = 1'b1;
    if ((action == ACT_HOLD) || (action == ACT_STALL)) begin
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and next ID/EX contents
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = RUN;
    idex_d  = idex_q;
    unique case (action)
      ACT_RESET: begin
        state_d = RUN;
        idex_d  = '0;
      end
      ACT_HOLD: begin
        state_d = HOLD;
        idex_d  = idex_q;
      end
      ACT_FLUSH: begin
        state_d = RUN;
        idex_d  = '0;
      end
      ACT_STALL: begin
        state_d = LU_BUBBLE;
        idex_d  = '0;
      end
      ACT_LOAD: begin
        state_d = RUN;
        idex_d  = id_in;
      end
      default: begin
        state_d = RUN;
        idex_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      idex_q  <= '0;
    end else begin
      state_q <= state_d;
      idex_q  <= idex_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------------
  assign IDEXRegRs    = idex_q.rs;
  assign IDEXRegRt    = idex_q.rt;
  assign IDEXRegRd    = idex_q.rd;
  assign IDEXRD1      = idex_q.rd1;
  assign IDEXRD2      = idex_q.rd2;
  assign IDEXImm32    = idex_q.imm;
  assign IDEXRegWrite = idex_q.ctrl.reg_write;
  assign IDEXMemRead  = idex_q.ctrl.mem_read;
  assign IDEXMemWrite = idex_q.ctrl.mem_write;
  assign IDEXMemtoReg = idex_q.ctrl.mem_to_reg;
  assign IDEXALUSrc   = idex_q.ctrl.alu_src;
  assign IDEXRegDst   = idex_q.ctrl.reg_dst;
  assign IDEXALUOp    = idex_q.ctrl.alu_op;
  assign IDEXValid    = idex_q.valid;

`ifdef IDEX_PERF_CNT_EN
  // ---------------------------------------------------------------------------
  // Saturating performance counters
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if ((action == ACT_STALL) && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if ((action == ACT_FLUSH) && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_idex_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_idex_stage_reg
//
// Scoreboard bench for idex_stage_reg. Each cycle the bench drives one set of
// ID-side inputs, checks the combinational hazard/enable outputs against a
// reference model, pushes the model's expected ID/EX contents into a queue,
// and after the clock edge pops and compares them with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_idex_stage_reg;

  localparam int unsigned TB_CNT_W = 4;

  localparam logic [9:0] CTRL_LW  = 10'b1101100000;
  localparam logic [9:0] CTRL_ADD = 10'b1000010010;

  typedef struct packed {
    logic        rst;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [9:0]  ctrl;
    logic        uses_rt;
    logic        valid;
    logic        flush;
    logic        ext;
  } stim_t;

  typedef struct packed {
    logic [4:0]          rs;
    logic [4:0]          rt;
    logic [4:0]          rd;
    logic [31:0]         rd1;
    logic [31:0]         rd2;
    logic [31:0]         imm;
    logic [9:0]          ctrl;
    logic                valid;
    logic [TB_CNT_W-1:0] stall_cnt;
    logic [TB_CNT_W-1:0] flush_cnt;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_rd1, id_rd2, id_imm;
  logic [9:0]  id_ctrl;
  logic        id_uses_rt, id_valid, branch_flush, ext_stall;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [31:0] ex_rd1, ex_rd2, ex_imm;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic        ex_alu_src, ex_reg_dst;
  logic [3:0]  ex_alu_op;
  logic        ex_valid;
  logic        pc_write, ifid_write, load_use_stall;
`ifdef IDEX_PERF_CNT_EN
  logic [TB_CNT_W-1:0] stall_cnt, flush_cnt;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  exp_t model;
  exp_t exp_q[$];

  idex_stage_reg #(
    .CNT_W(TB_CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .IDRegRs     (id_rs),
    .IDRegRt     (id_rt),
    .IDRegRd     (id_rd),
    .IDRD1       (id_rd1),
    .IDRD2       (id_rd2),
    .IDImm32     (id_imm),
    .IDCtrl      (id_ctrl),
    .IDUsesRt    (id_uses_rt),
    .IDValid     (id_valid),
    .BranchFlush (branch_flush),
    .ExtStall    (ext_stall),
    .IDEXRegRs   (ex_rs),
    .IDEXRegRt   (ex_rt),
    .IDEXRegRd   (ex_rd),
    .IDEXRD1     (ex_rd1),
    .IDEXRD2     (ex_rd2),
    .IDEXImm32   (ex_imm),
    .IDEXRegWrite(ex_reg_write),
    .IDEXMemRead (ex_mem_read),
    .IDEXMemWrite(ex_mem_write),
    .IDEXMemtoReg(ex_mem_to_reg),
    .IDEXALUSrc  (ex_alu_src),
    .IDEXRegDst  (ex_reg_dst),
    .IDEXALUOp   (ex_alu_op),
    .IDEXValid   (ex_valid),
    .PCWrite     (pc_write),
    .IFIDWrite   (ifid_write),
    .LoadUseStall(load_use_stall)
`ifdef IDEX_PERF_CNT_EN
    ,
    .StallCnt    (stall_cnt),
    .FlushCnt    (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic stim_t instr(input logic [4:0] rs, input logic [4:0] rt,
                                  input logic [9:0] ctrl, input logic uses_rt,
                                  input logic [31:0] rd1);
    stim_t s;
    s         = '0;
    s.rs      = rs;
    s.rt      = rt;
    s.rd      = rs ^ rt ^ 5'd17;
    s.rd1     = rd1;
    s.rd2     = ~rd1;
    s.imm     = {rd1[15:0], rd1[31:16]};
    s.ctrl    = ctrl;
    s.uses_rt = uses_rt;
    s.valid   = 1'b1;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    logic lus_e, pcw_e;
    exp_t e;
    rst          = s.rst;
    id_rs        = s.rs;
    id_rt        = s.rt;
    id_rd        = s.rd;
    id_rd1       = s.rd1;
    id_rd2       = s.rd2;
    id_imm       = s.imm;
    id_ctrl      = s.ctrl;
    id_uses_rt   = s.uses_rt;
    id_valid     = s.valid;
    branch_flush = s.flush;
    ext_stall    = s.ext;
    @(negedge clk);

    lus_e = !s.rst && s.valid && model.valid && model.ctrl[8] &&
            (model.rt != 5'd0) &&
            ((model.rt == s.rs) || (s.uses_rt && (model.rt == s.rt)));
    pcw_e = s.rst || (!s.ext && (s.flush || !lus_e));
    check("load_use_stall", 64'(load_use_stall), 64'(lus_e));
    check("pc_write", 64'(pc_write), 64'(pcw_e));
    check("ifid_write", 64'(ifid_write), 64'(pcw_e));

    if (s.rst) begin
      model = '0;
    end else if (!s.ext) begin
      if (s.flush) begin
        if (model.flush_cnt != '1) model.flush_cnt = model.flush_cnt + 1'b1;
      end else if (lus_e) begin
        if (model.stall_cnt != '1) model.stall_cnt = model.stall_cnt + 1'b1;
      end
      if (s.flush || lus_e) begin
        model.rs = '0; model.rt = '0; model.rd = '0;
        model.rd1 = '0; model.rd2 = '0; model.imm = '0;
        model.ctrl = '0; model.valid = 1'b0;
      end else begin
        model.rs = s.rs; model.rt = s.rt; model.rd = s.rd;
        model.rd1 = s.rd1; model.rd2 = s.rd2; model.imm = s.imm;
        model.ctrl = s.ctrl; model.valid = s.valid;
      end
    end
    exp_q.push_back(model);

    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 64'(0), 64'(1));
    end else begin
      e = exp_q.pop_front();
      check("idex_rs", 64'(ex_rs), 64'(e.rs));
      check("idex_rt", 64'(ex_rt), 64'(e.rt));
      check("idex_rd", 64'(ex_rd), 64'(e.rd));
      check("idex_rd1", 64'(ex_rd1), 64'(e.rd1));
      check("idex_rd2", 64'(ex_rd2), 64'(e.rd2));
      check("idex_imm", 64'(ex_imm), 64'(e.imm));
      check("idex_ctrl", 64'({ex_reg_write, ex_mem_read, ex_mem_write,
                              ex_mem_to_reg, ex_alu_src, ex_reg_dst,
                              ex_alu_op}), 64'(e.ctrl));
      check("idex_valid", 64'(ex_valid), 64'(e.valid));
`ifdef IDEX_PERF_CNT_EN
      check("stall_cnt", 64'(stall_cnt), 64'(e.stall_cnt));
      check("flush_cnt", 64'(flush_cnt), 64'(e.flush_cnt));
`endif
    end
  endtask

  initial begin
    stim_t s;
    model = '0;

    // Reset, with flush and hold asserted to show reset wins.
    s = '0; s.rst = 1'b1; s.ext = 1'b1; s.flush = 1'b1;
    apply(s);
    s = '0; s.rst = 1'b1;
    apply(s);

    // Load-use on rs: lw $8, then add reading $8 (stall, bubble, then load).
    apply(instr(5'd2, 5'd8, CTRL_LW, 1'b0, 32'h0000_1000));
    apply(instr(5'd8, 5'd3, CTRL_ADD, 1'b1, 32'h1234_5678));
    apply(instr(5'd8, 5'd3, CTRL_ADD, 1'b1, 32'h1234_5678));
    check("rs_after_stall", 64'(ex_rs), 64'(8));

    // Load-use on rt with IDUsesRt=1.
    apply(instr(5'd1, 5'd11, CTRL_LW, 1'b0, 32'h0000_2000));
    apply(instr(5'd4, 5'd11, CTRL_ADD, 1'b1, 32'h0BAD_F00D));
    apply(instr(5'd4, 5'd11, CTRL_ADD, 1'b1, 32'h0BAD_F00D));

    // No false hazard: lw $0 then rs=0; lw $9 then rt=9 not used.
    apply(instr(5'd1, 5'd0, CTRL_LW, 1'b0, 32'h0000_3000));
    apply(instr(5'd0, 5'd0, CTRL_ADD, 1'b1, 32'hAAAA_5555));
    apply(instr(5'd1, 5'd9, CTRL_LW, 1'b0, 32'h0000_4000));
    apply(instr(5'd1, 5'd9, CTRL_ADD, 1'b0, 32'h5555_AAAA));

    // Invalid ID slot never stalls.
    apply(instr(5'd1, 5'd12, CTRL_LW, 1'b0, 32'h0000_5000));
    s = instr(5'd12, 5'd2, CTRL_ADD, 1'b1, 32'h7777_0000); s.valid = 1'b0;
    apply(s);

    // Flush beats load-use; hold beats both.
    apply(instr(5'd1, 5'd5, CTRL_LW, 1'b0, 32'h0000_6000));
    s = instr(5'd5, 5'd2, CTRL_ADD, 1'b1, 32'hCAFE_0001); s.flush = 1'b1;
    apply(s);
    apply(instr(5'd1, 5'd5, CTRL_LW, 1'b0, 32'h0000_7000));
    s = instr(5'd5, 5'd2, CTRL_ADD, 1'b1, 32'hCAFE_0002);
    s.flush = 1'b1; s.ext = 1'b1;
    apply(s);
    s.ext = 1'b0; s.flush = 1'b0;
    apply(s);
    apply(s);

    // Hold for 3 cycles while IDRD1 changes, then release.
    apply(instr(5'd3, 5'd4, CTRL_ADD, 1'b1, 32'h1111_1111));
    for (int i = 0; i < 3; i++) begin
      s = instr(5'd6, 5'd7, CTRL_ADD, 1'b1, 32'hDEAD_BEEF ^ 32'(i));
      s.ext = 1'b1;
      apply(s);
      check("hold_rd1", 64'(ex_rd1), 64'(32'h1111_1111));
    end
    apply(instr(5'd6, 5'd7, CTRL_ADD, 1'b1, 32'hDEAD_BEEF));
    check("release_rd1", 64'(ex_rd1), 64'(32'hDEAD_BEEF));

    // Hazard present when HOLD starts still bubbles after HOLD ends.
    apply(instr(5'd1, 5'd6, CTRL_LW, 1'b0, 32'h0000_8000));
    s = instr(5'd6, 5'd1, CTRL_ADD, 1'b1, 32'h2222_2222); s.ext = 1'b1;
    apply(s);
    apply(s);
    s.ext = 1'b0;
    apply(s);
    apply(s);

    // Reset during LU_BUBBLE.
    apply(instr(5'd1, 5'd7, CTRL_LW, 1'b0, 32'h0000_9000));
    apply(instr(5'd7, 5'd2, CTRL_ADD, 1'b1, 32'h3333_3333));
    s = instr(5'd7, 5'd2, CTRL_ADD, 1'b1, 32'h3333_3333); s.rst = 1'b1;
    apply(s);
    apply(instr(5'd7, 5'd2, CTRL_ADD, 1'b1, 32'h3333_3333));

    // 20 stall events; the stall counter saturates at all-ones.
    for (int i = 0; i < 20; i++) begin
      apply(instr(5'd1, 5'd4, CTRL_LW, 1'b0, 32'(i)));
      apply(instr(5'd4, 5'd2, CTRL_ADD, 1'b1, 32'h4444_0000));
    end
`ifdef IDEX_PERF_CNT_EN
    check("stall_cnt_sat", 64'(stall_cnt), 64'(15));
`endif

    // Randomised traffic on a small register range to provoke hazards.
    for (int i = 0; i < 200; i++) begin
      s = '0;
      s.rst     = ($urandom_range(0, 40) == 0);
      s.rs      = 5'($urandom_range(0, 3));
      s.rt      = 5'($urandom_range(0, 3));
      s.rd      = 5'($urandom_range(0, 31));
      s.rd1     = $urandom;
      s.rd2     = $urandom;
      s.imm     = $urandom;
      s.ctrl    = 10'($urandom);
      s.ctrl[8] = ($urandom_range(0, 1) == 1);
      s.uses_rt = ($urandom_range(0, 1) == 1);
      s.valid   = ($urandom_range(0, 7) != 0);
      s.flush   = ($urandom_range(0, 7) == 0);
      s.ext     = ($urandom_range(0, 7) == 0);
      apply(s);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
